weight_enum8: RTL



---
 rtl/weight_enum8_if.sv | 21 ++
 rtl/weight_enum8.sv | 73 +++++++
 2 files changed

// File: rtl/weight_enum8_if.sv
// weight_enum8_if: start/abort request side and valid/ready word stream of weight_enum8
interface weight_enum8_if;
  logic       start;
  logic [3:0] weight;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_word;
  logic [6:0] out_index;
  logic       out_last;
  logic       busy;
  logic       err;
  modport master (
    output start, weight, abort, out_ready,
    input  out_valid, out_word, out_index, out_last, busy, err
  );
  modport slave (
    input  start, weight, abort, out_ready,
    output out_valid, out_word, out_index, out_last, busy, err
  );
endinterface

// File: rtl/weight_enum8.sv
// weight_enum8: streams every 8-bit word of a requested popcount exactly once, in numeric order
module weight_enum8 #(
  parameter bit DESCENDING = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  weight_enum8_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  logic [0:0] state;
  logic [7:0] word;
  logic [7:0] nxt;
  logic [7:0] first;
  logic [6:0] idx;
  logic [6:0] last_idx;
  logic       err_q;
  logic       go;
  logic       fire;
  logic       last;
  // next larger word of equal popcount: bump the lowest 1-run, right-justify the leftover bits
  function automatic logic [7:0] succ(input logic [7:0] x);
    logic [7:0] c;
    logic [7:0] r;
    logic [3:0] tz;
    c  = x & (~x + 8'd1);
    r  = x + c;
    tz = 4'd0;
    for (int i = 7; i >= 0; i--) if (x[i]) tz = 4'(i);
    return r | ((x ^ r) >> (tz + 4'd2));
  endfunction
  function automatic logic [6:0] count_m1(input logic [3:0] w);
    case (w)
      4'd0, 4'd8: return 7'd0;
      4'd1, 4'd7: return 7'd7;
      4'd2, 4'd6: return 7'd27;
      4'd3, 4'd5: return 7'd55;
      default:    return 7'd69;
    endcase
  endfunction
  // complementing maps weight w onto 8-w and reverses order, so predecessor = ~succ(~x)
  assign nxt   = DESCENDING ? ~succ(~word) : succ(word);
  assign first = DESCENDING ? 8'hff << (4'd8 - bus.weight) : 8'hff >> (4'd8 - bus.weight);
  assign go    = state == IDLE && bus.start && bus.weight <= 4'd8;
  assign fire  = state == EMIT && bus.out_ready;
  assign last  = state == EMIT && idx == last_idx;
  assign bus.out_valid = state == EMIT;
  assign bus.busy      = state == EMIT;
  assign bus.out_word  = word;
  assign bus.out_index = idx;
  assign bus.out_last  = last;
  assign bus.err       = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      idx      <= '0;
      last_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= state == IDLE && bus.start && bus.weight > 4'd8;
      if (go) begin
        state    <= EMIT;
        word     <= first;
        idx      <= '0;
        last_idx <= count_m1(bus.weight);
      end else if (state == EMIT && (bus.abort || (fire && last))) state <= IDLE;
      else if (fire) begin
        word <= nxt;
        idx  <= idx + 7'd1;
      end
    end
endmodule
